// File: rtl/sample_frame_ctrl_if.sv
// Configuration word handshake between the word source and sample_frame_ctrl.
// The source presents cfg_data with cfg_valid; the sequencer answers with cfg_ready.
interface sample_frame_ctrl_if #(
  parameter int BIT_CHIP = 6
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [BIT_CHIP-1:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/sample_frame_ctrl.sv
// Frame sequencer: loads NODE config words, shifts them serially to the chip,
// latches, then lets the chip run n_low clk_low periods, for n_frames frames.
module sample_frame_ctrl #(
  parameter int BIT_CHIP = 6,
  parameter int NODE     = 16,
  parameter int LW       = 1,
  parameter int NLOW_W   = 16,
  parameter int NFRM_W   = 8
) (
  input  logic              clk_main,
  input  logic              clr,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [NFRM_W-1:0] i_n_frames,
  input  logic [NLOW_W-1:0] i_n_low,
  sample_frame_ctrl_if.slave cfg,
  input  logic              i_frame_sync,
  input  logic              i_data_tick,
  input  logic              i_low_tick,
  output logic              o_sdo,
  output logic              o_sen,
  output logic              o_latch_out,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_done,
  output logic              o_aborted,
  output logic [NFRM_W-1:0] o_frame_cnt
);

  localparam int TOT = BIT_CHIP * NODE;
  localparam int WCW = (NODE > 1) ? $clog2(NODE) : 1;
  localparam int BCW = $clog2(TOT);
  localparam int LCW = (LW > 1) ? $clog2(LW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SYNC,
    S_SHIFT,
    S_LATCH,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [TOT-1:0]    r_shreg;
  logic [WCW-1:0]    r_word_cnt;
  logic [BCW-1:0]    r_bit_cnt;
  logic [LCW-1:0]    r_lat_cnt;
  logic [NLOW_W-1:0] r_run_cnt;
  logic [NLOW_W-1:0] r_nlow;
  logic [NFRM_W-1:0] r_nfrm;
  logic [NFRM_W-1:0] r_frame_cnt;
  logic              r_sdo;
  logic              r_sen;
  logic              r_latch;
  logic              r_frame_done;
  logic              r_done;
  logic              r_aborted;

  logic              w_abort;
  logic              w_hs;
  logic              w_word_last;
  logic              w_bit_last;
  logic              w_lat_last;
  logic              w_run_last;
  logic              w_frm_last;
  logic [NLOW_W-1:0] w_nlow_eff;
  logic [NLOW_W-1:0] w_run_inc;
  logic [NFRM_W-1:0] w_frm_inc;

  assign w_abort     = i_abort && (r_state != S_IDLE)
                       && (r_state != S_DONE);
  assign w_hs        = cfg.cfg_valid && (r_state == S_LOAD);
  assign w_word_last = r_word_cnt == WCW'(NODE - 1);
  assign w_bit_last  = r_bit_cnt == BCW'(TOT - 1);
  assign w_lat_last  = r_lat_cnt == LCW'(LW - 1);
  // n_low of zero still gives the chip one clk_low period
  assign w_nlow_eff  = (r_nlow == '0) ? NLOW_W'(1) : r_nlow;
  assign w_run_inc   = r_run_cnt + 1'b1;
  assign w_run_last  = w_run_inc == w_nlow_eff;
  assign w_frm_inc   = r_frame_cnt + 1'b1;
  assign w_frm_last  = w_frm_inc == r_nfrm;

  always_ff @(posedge clk_main) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start)
          w_nxt = (i_n_frames == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (w_hs && w_word_last) w_nxt = S_SYNC;
      end
      S_SYNC: begin
        if (i_frame_sync) w_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (i_data_tick && w_bit_last) w_nxt = S_LATCH;
      end
      S_LATCH: begin
        if (i_data_tick && w_lat_last) w_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_low_tick && w_run_last)
          w_nxt = w_frm_last ? S_DONE : S_LOAD;
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (w_abort) w_nxt = S_DONE;
  end

  always_ff @(posedge clk_main) begin
    if (clr) begin
      r_shreg      <= '0;
      r_word_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_lat_cnt    <= '0;
      r_run_cnt    <= '0;
      r_nlow       <= '0;
      r_nfrm       <= '0;
      r_frame_cnt  <= '0;
      r_sdo        <= 1'b0;
      r_sen        <= 1'b0;
      r_latch      <= 1'b0;
      r_frame_done <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_done       <= (r_state == S_DONE);
      if (w_abort) begin
        r_sdo     <= 1'b0;
        r_sen     <= 1'b0;
        r_latch   <= 1'b0;
        r_aborted <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_nfrm      <= i_n_frames;
              r_nlow      <= i_n_low;
              r_frame_cnt <= '0;
              r_aborted   <= 1'b0;
              r_word_cnt  <= '0;
            end
          end
          S_LOAD: begin
            if (w_hs) begin
              r_shreg <= (r_shreg << BIT_CHIP)
                         | TOT'(cfg.cfg_data);
              r_word_cnt <= w_word_last ? '0
                            : r_word_cnt + 1'b1;
            end
          end
          S_SYNC: begin
            if (i_frame_sync) begin
              r_sen     <= 1'b1;
              r_sdo     <= r_shreg[TOT-1];
              r_bit_cnt <= '0;
            end
          end
          S_SHIFT: begin
            if (i_data_tick) begin
              if (w_bit_last) begin
                r_sdo     <= 1'b0;
                r_sen     <= 1'b0;
                r_latch   <= 1'b1;
                r_lat_cnt <= '0;
                r_bit_cnt <= '0;
              end else begin
                r_shreg   <= r_shreg << 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_sdo     <= r_shreg[TOT-2];
              end
            end
          end
          S_LATCH: begin
            if (i_data_tick) begin
              if (w_lat_last) begin
                r_latch   <= 1'b0;
                r_run_cnt <= '0;
              end else begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
              end
            end
          end
          S_RUN: begin
            if (i_low_tick) begin
              if (w_run_last) begin
                r_frame_done <= 1'b1;
                r_frame_cnt  <= w_frm_inc;
                r_run_cnt    <= '0;
                r_word_cnt   <= '0;
              end else begin
                r_run_cnt <= w_run_inc;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cfg.cfg_ready = (r_state == S_LOAD);
  assign o_sdo         = r_sdo;
  assign o_sen         = r_sen;
  assign o_latch_out   = r_latch;
  assign o_busy        = (r_state != S_IDLE);
  assign o_frame_done  = r_frame_done;
  assign o_done        = r_done;
  assign o_aborted     = r_aborted;
  assign o_frame_cnt   = r_frame_cnt;

endmodule
